// File: rtl/dmem_line_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_line_ctrl
//
// Backing data memory for the D-cache refill / write-back port. A request
// (one 128-bit line) is accepted in IDLE, held for LATENCY rising edges, and
// then answered with a single-cycle mem_rvalid_o pulse. Writes commit to the
// array on the same edge that raises the response, so a read that follows a
// write to the same line always sees the new data.
//
// Optional feature (compile-time macro): DMEM_BOUNDS_CHK_EN
//   Adds err_o. Requests whose line number (mem_addr_i[31:4]) is at or above
//   DEPTH_LINES are still timed normally, but a write is dropped, a read
//   returns all-zeros, and err_o is high for the response cycle.
//   Without the macro, out-of-range addresses alias modulo DEPTH_LINES.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset (array contents are kept)
//   mem_addr_i    byte address; line index = mem_addr_i[4 +: log2(DEPTH_LINES)]
//   mem_wdata_i   write line
//   mem_we_i      1 = write, 0 = read
//   mem_cs_i      request valid, sampled only in IDLE
//   mem_rdata_o   response line, holds its value outside the response cycle
//   mem_rvalid_o  one-cycle response pulse (reads and writes), registered
//   err_o         out-of-range flag for the response cycle (macro builds only)
// -----------------------------------------------------------------------------
module dmem_line_ctrl #(
   parameter int LINE_W      = 128,
   parameter int DEPTH_LINES = 1024,
   parameter int LATENCY     = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [31:0]       mem_addr_i,
   input  logic [LINE_W-1:0] mem_wdata_i,
   input  logic              mem_we_i,
   input  logic              mem_cs_i,
   output logic [LINE_W-1:0] mem_rdata_o,
   output logic              mem_rvalid_o
`ifdef DMEM_BOUNDS_CHK_EN
   ,
   output logic              err_o
`endif
);

   localparam int IDX_W = $clog2(DEPTH_LINES);
   // The counter is loaded with LATENCY-1 so the response edge lands exactly
   // LATENCY edges after acceptance (LATENCY=1 gives a single BUSY cycle).
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                we_q, we_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                mem_wr_en;
   logic [LINE_W-1:0]   line_mem_q [DEPTH_LINES];

`ifdef DMEM_BOUNDS_CHK_EN
   logic                req_oob;
   logic                oob_q, oob_d;
   logic                err_q, err_d;

   assign req_oob = ({4'b0000, mem_addr_i[31:4]} >= 32'(DEPTH_LINES));
`endif

   // Byte-offset bits and (in the wrapping build) the bits above the index
   // are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr_i[3:0], mem_addr_i[31:4+IDX_W]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      mem_wr_en = 1'b0;
`ifdef DMEM_BOUNDS_CHK_EN
      oob_d     = oob_q;
      err_d     = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (mem_cs_i) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
               idx_d   = mem_addr_i[4 +: IDX_W];
               we_d    = mem_we_i;
               wdata_d = mem_wdata_i;
`ifdef DMEM_BOUNDS_CHK_EN
               oob_d   = req_oob;
`endif
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               // Response edge: commit the write / fetch the read together
               // with raising rvalid.
               state_d  = RESP;
               rvalid_d = 1'b1;
`ifdef DMEM_BOUNDS_CHK_EN
               err_d    = oob_q;
               if (oob_q) begin
                  rdata_d = '0;
               end else
`endif
               if (we_q) begin
                  mem_wr_en = 1'b1;
                  rdata_d   = wdata_q;
               end else begin
                  rdata_d   = line_mem_q[idx_q];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            // cs is not sampled here; the cache updates its request on the
            // RESP edge, so the next acceptance is at the following IDLE edge.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
`ifdef DMEM_BOUNDS_CHK_EN
         oob_q    <= 1'b0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
`ifdef DMEM_BOUNDS_CHK_EN
         oob_q    <= oob_d;
         err_q    <= err_d;
`endif
      end
   end

   // Line array has no reset; an aborted request never reaches the commit
   // because reset forces the FSM back to IDLE.
   always_ff @(posedge clk_i) begin
      if (mem_wr_en) begin
         line_mem_q[idx_q] <= wdata_q;
      end
   end

   assign mem_rdata_o  = rdata_q;
   assign mem_rvalid_o = rvalid_q;
`ifdef DMEM_BOUNDS_CHK_EN
   assign err_o        = err_q;
`endif

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_line_ctrl
//
// Directed plus randomized bench for dmem_line_ctrl. One instance uses the
// default LATENCY=4 / DEPTH_LINES=1024 configuration, a second uses
// LATENCY=1. Expected responses come from a line-addressed associative-array
// model of the memory and from the fixed request-to-response distance.
// -----------------------------------------------------------------------------
module tb_dmem_line_ctrl;

   localparam int LAT   = 4;
   localparam int DEPTH = 1024;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  addr;
   logic [127:0] wdata;
   logic         we;
   logic         cs;
   logic [127:0] rdata;
   logic         rvalid;

   logic [31:0]  addr1;
   logic [127:0] wdata1;
   logic         we1;
   logic         cs1;
   logic [127:0] rdata1;
   logic         rvalid1;

`ifdef DMEM_BOUNDS_CHK_EN
   logic         err;
   logic         err1;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int accCyc = 0;

   int           pulseCyc[$];
   logic [127:0] pulseData[$];
   logic         pulseErr[$];

   logic [127:0] modelMem [int];

   // Main instance with the default latency.
   dmem_line_ctrl #(.LINE_W(128), .DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_addr_i   (addr),
      .mem_wdata_i  (wdata),
      .mem_we_i     (we),
      .mem_cs_i     (cs),
      .mem_rdata_o  (rdata),
      .mem_rvalid_o (rvalid)
`ifdef DMEM_BOUNDS_CHK_EN
      ,
      .err_o        (err)
`endif
   );

   // Second instance exercising the shortest legal latency.
   dmem_line_ctrl #(.LINE_W(128), .DEPTH_LINES(DEPTH), .LATENCY(1)) dut1 (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_addr_i   (addr1),
      .mem_wdata_i  (wdata1),
      .mem_we_i     (we1),
      .mem_cs_i     (cs1),
      .mem_rdata_o  (rdata1),
      .mem_rvalid_o (rvalid1)
`ifdef DMEM_BOUNDS_CHK_EN
      ,
      .err_o        (err1)
`endif
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Edge counter used to time responses against the acceptance edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Record every response pulse of the main instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         pulseCyc.push_back(cyc);
         pulseData.push_back(rdata);
`ifdef DMEM_BOUNDS_CHK_EN
         pulseErr.push_back(err);
`else
         pulseErr.push_back(1'b0);
`endif
      end
   end

   function automatic logic [127:0] randLine();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present one request to the main instance; returns after the acceptance
   // edge with cs already dropped.
   task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [127:0] d);
      @(negedge clk);
      addr  = a;
      we    = w;
      wdata = d;
      cs    = 1'b1;
      @(posedge clk);
      #1 accCyc = cyc;
      @(negedge clk);
      cs = 1'b0;
   endtask

   // Behavioural memory: lines alias modulo DEPTH unless bounds checking is
   // built in, in which case out-of-range lines never change and read as 0.
   task automatic modelAccess(input logic [31:0] a, input logic w, input logic [127:0] d,
                              output logic [127:0] expData, output logic expErr,
                              output bit dataKnown);
      int unsigned line;
      int          idx;
      bit          oob;
      line      = a >> 4;
      idx       = int'(line % DEPTH);
      oob       = 1'b0;
      expErr    = 1'b0;
      dataKnown = 1'b1;
      expData   = '0;
`ifdef DMEM_BOUNDS_CHK_EN
      oob = (line >= DEPTH);
`endif
      if (oob) begin
         expErr    = 1'b1;
         dataKnown = !w;
      end else if (w) begin
         modelMem[idx] = d;
         expData       = d;
      end else if (modelMem.exists(idx)) begin
         expData = modelMem[idx];
      end else begin
         dataKnown = 1'b0;
      end
   endtask

   // Bounded wait until the pulse log holds at least 'target' entries.
   task automatic waitPulse(input int target, output bit ok);
      for (int i = 0; i < 40 && pulseCyc.size() < target; i++) begin
         @(negedge clk);
         #1;
      end
      ok = (pulseCyc.size() >= target);
   endtask

   // Full single request: stimulus, model update, timing/data/width checks.
   task automatic runTransaction(input string tag, input logic [31:0] a, input logic w,
                                 input logic [127:0] d);
      int           base;
      bit           ok;
      bit           known;
      logic [127:0] expData;
      logic         expErr;
      base = pulseCyc.size();
      applyStimulus(a, w, d);
      modelAccess(a, w, d, expData, expErr, known);
      waitPulse(base + 1, ok);
      checkOutput({tag, "_seen"}, 128'(ok), 128'd1);
      if (ok) begin
         checkOutput({tag, "_lat"}, 128'(pulseCyc[base] - accCyc), 128'(LAT));
         if (known) checkOutput({tag, "_data"}, pulseData[base], expData);
`ifdef DMEM_BOUNDS_CHK_EN
         checkOutput({tag, "_err"}, 128'(pulseErr[base]), 128'(expErr));
`endif
         @(negedge clk);
         #1 checkOutput({tag, "_width"}, 128'(rvalid), 128'd0);
      end
   endtask

   initial begin
      int           base;
      bit           ok;
      bit           known;
      logic [127:0] expA;
      logic [127:0] expB;
      logic [127:0] expData;
      logic         expErr;
      logic [127:0] d1;
      logic [31:0]  a;

      rst_n  = 1'b0;
      addr   = '0;
      wdata  = '0;
      we     = 1'b0;
      cs     = 1'b0;
      addr1  = '0;
      wdata1 = '0;
      we1    = 1'b0;
      cs1    = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_rvalid", 128'(rvalid), 128'd0);
      checkOutput("rst_rdata", rdata, 128'd0);
`ifdef DMEM_BOUNDS_CHK_EN
      checkOutput("rst_err", 128'(err), 128'd0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Write then read the same line.
      runTransaction("wr100", 32'h0000_0100, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF);
      runTransaction("rd100", 32'h0000_0100, 1'b0, '0);

      // Write-back then allocate with cs held high across the response.
      runTransaction("pre300", 32'h0000_0300, 1'b1, randLine());
      d1   = randLine();
      base = pulseCyc.size();
      @(negedge clk);
      addr  = 32'h0000_0200;
      we    = 1'b1;
      wdata = d1;
      cs    = 1'b1;
      @(posedge clk);
      #1 accCyc = cyc;
      modelAccess(32'h0000_0200, 1'b1, d1, expA, expErr, known);
      modelAccess(32'h0000_0300, 1'b0, '0, expB, expErr, known);
      waitPulse(base + 1, ok);
      addr  = 32'h0000_0300;
      we    = 1'b0;
      wdata = randLine();
      waitPulse(base + 2, ok);
      cs = 1'b0;
      repeat (12) @(negedge clk);
      #1 checkOutput("b2b_count", 128'(pulseCyc.size() - base), 128'd2);
      if (pulseCyc.size() >= base + 2) begin
         checkOutput("b2b_lat", 128'(pulseCyc[base] - accCyc), 128'(LAT));
         checkOutput("b2b_gap", 128'(pulseCyc[base+1] - pulseCyc[base]), 128'(LAT + 2));
         checkOutput("b2b_dataA", pulseData[base], expA);
         checkOutput("b2b_dataB", pulseData[base+1], expB);
      end
      runTransaction("rd200", 32'h0000_0200, 1'b0, '0);

      // Input churn while BUSY must not disturb the accepted read.
      base = pulseCyc.size();
      applyStimulus(32'h0000_0100, 1'b0, '0);
      modelAccess(32'h0000_0100, 1'b0, '0, expData, expErr, known);
      for (int i = 0; i < LAT - 1; i++) begin
         addr  = 32'h100 * $urandom_range(1, 3);
         we    = 1'($urandom_range(0, 1));
         wdata = randLine();
         cs    = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      cs    = 1'b0;
      we    = 1'b1;
      addr  = 32'h0000_0200;
      wdata = randLine();
      waitPulse(base + 1, ok);
      checkOutput("churn_seen", 128'(ok), 128'd1);
      if (ok) begin
         checkOutput("churn_lat", 128'(pulseCyc[base] - accCyc), 128'(LAT));
         checkOutput("churn_data", pulseData[base], expData);
      end
      we = 1'b0;
      repeat (2) @(negedge clk);
      runTransaction("churn_rd100", 32'h0000_0100, 1'b0, '0);
      runTransaction("churn_rd200", 32'h0000_0200, 1'b0, '0);
      runTransaction("churn_rd300", 32'h0000_0300, 1'b0, '0);

      // Reset in the middle of BUSY aborts the write and its response.
      runTransaction("pre400", 32'h0000_0400, 1'b1, randLine());
      base = pulseCyc.size();
      applyStimulus(32'h0000_0400, 1'b1, '1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_rvalid", 128'(rvalid), 128'd0);
      checkOutput("midrst_rdata", rdata, 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1 checkOutput("midrst_nopulse", 128'(pulseCyc.size() - base), 128'd0);
      runTransaction("rd400_old", 32'h0000_0400, 1'b0, '0);

      // Address wrap (or bounds error when the check is built in).
      runTransaction("pre0000", 32'h0000_0000, 1'b1, randLine());
      runTransaction("wr4000", 32'h0000_4000, 1'b1, {16{8'hAA}});
      runTransaction("rd0000", 32'h0000_0000, 1'b0, '0);
      runTransaction("rd4000", 32'h0000_4000, 1'b0, '0);

      // Randomized traffic over a small pool of lines with random alias bits.
      for (int i = 0; i < 8; i++) begin
         runTransaction("rnd_init", 32'((16 + i) << 4), 1'b1, randLine());
      end
      for (int i = 0; i < 16; i++) begin
         a = (32'($urandom_range(0, 3)) << 14) | (32'(16 + $urandom_range(0, 7)) << 4)
             | 32'($urandom_range(0, 15));
         runTransaction("rnd", a, 1'($urandom_range(0, 1)), randLine());
      end

      // LATENCY=1 instance: response one edge after acceptance, then idle.
      d1 = randLine();
      @(negedge clk);
      addr1  = 32'h0000_0500;
      we1    = 1'b1;
      wdata1 = d1;
      cs1    = 1'b1;
      @(posedge clk);
      #1 checkOutput("lat1_wr_k", 128'(rvalid1), 128'd0);
      cs1 = 1'b0;
      @(posedge clk);
      #1 checkOutput("lat1_wr_k1", 128'(rvalid1), 128'd1);
      checkOutput("lat1_wr_data", rdata1, d1);
      @(posedge clk);
      #1 checkOutput("lat1_wr_k2", 128'(rvalid1), 128'd0);
      @(negedge clk);
      we1 = 1'b0;
      cs1 = 1'b1;
      @(posedge clk);
      #1 cs1 = 1'b0;
      @(posedge clk);
      #1 checkOutput("lat1_rd_k1", 128'(rvalid1), 128'd1);
      checkOutput("lat1_rd_data", rdata1, d1);
      @(posedge clk);
      #1 checkOutput("lat1_rd_k2", 128'(rvalid1), 128'd0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_line_ctrl.md
Name: dmem_line_ctrl

Overview:
- Backing data memory on the D-cache refill/write-back port of the MEM stage.
- Accepts 128-bit line requests (address, write data, write enable, chip select).
- Holds each accepted request for a fixed, parameterised latency, commits writes, and returns read lines with a one-cycle valid pulse.
- Sits directly downstream of the MEM stage's mem_addr/mem_wdata/mem_we/mem_cs outputs and drives its mem_rdata/mem_rvalid inputs.

Parameters:
- LINE_W, 128, line width in bits; must equal the cache line width.
- DEPTH_LINES, 1024, number of lines in the array; power of two.
- LATENCY, 4, rising edges from request acceptance to the response edge; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- mem_addr_i  input  32  byte address; line index = mem_addr_i[4 +: log2(DEPTH_LINES)]; bits [3:0] ignored.
- mem_wdata_i  input  LINE_W  write line.
- mem_we_i  input  1  1 = write, 0 = read.
- mem_cs_i  input  1  request valid.
- mem_rdata_o  output  LINE_W  response line.
- mem_rvalid_o  output  1  one-cycle response pulse for both reads and writes.
- err_o  output  1  present only with DMEM_BOUNDS_CHK_EN.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE, counter=0, mem_rvalid_o=0, mem_rdata_o=0, err_o=0.
  - The memory array is never reset.
  - Reset mid-operation aborts the request: no write commit, no response.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: on a rising edge with mem_cs_i=1, latch addr index, we and wdata; load counter=LATENCY-1; go to BUSY. mem_cs_i=0 stays in IDLE.
  - BUSY: inputs ignored; changes to addr/we/wdata/cs have no effect. Counter decrements each edge. On the edge where counter==0, go to RESP, and in that same edge:
    - write: array[idx] <= latched wdata; mem_rdata_o <= latched wdata.
    - read: mem_rdata_o <= array[idx].
  - RESP: mem_rvalid_o=1 for exactly this cycle. Inputs are not sampled. Next edge goes unconditionally to IDLE.
- Latency: with acceptance at edge k, mem_rvalid_o is high between edges k+LATENCY and k+LATENCY+1.
  - With LATENCY=1, BUSY lasts one cycle.
- mem_rdata_o holds its last value outside RESP.
- mem_rvalid_o is registered with no combinational path from inputs.
- Back-to-back requests:
  - mem_cs_i held high across a response produces a new acceptance at the first IDLE edge after RESP.
  - The cache changes its request at the RESP edge, so no duplicate service occurs.
  - Minimum request spacing is LATENCY+2 cycles.
- A single-cycle cs pulse sampled in IDLE is fully serviced.
- Read-after-write to the same line returns the newly written data, because the write commits at the response edge.
- Address wrap, without the optional feature: index bits above log2(DEPTH_LINES)+4 are ignored, so addresses alias modulo DEPTH_LINES lines.

Optional Feature:
- Macro: DMEM_BOUNDS_CHK_EN.
- With the macro:
  - Port err_o exists.
  - A request whose mem_addr_i[31:4] >= DEPTH_LINES is still timed normally.
  - At the response edge: a write is discarded (array unchanged); a read returns all-zeros in mem_rdata_o.
  - err_o=1 during the RESP cycle only.
- Without the macro: no err_o port; out-of-range addresses wrap as above.

Test Plan (LATENCY=4, DEPTH_LINES=1024):
- Write then read:
  - Write addr 0x0000_0100, data 0x0123..CDEF, cs pulse at edge 0 -> rvalid high between edges 4 and 5, rdata=written data.
  - Then read 0x0000_0100 -> rvalid 4 edges after acceptance, rdata=0x0123..CDEF.
- Write-back then allocate:
  - cs held high: write A=0x200, then at the RESP edge switch to read B=0x300 -> exactly two rvalid pulses, 6 cycles apart.
  - Read B returns its prior contents; A updated.
- Input churn: after accepting read 0x100, toggle addr/we/wdata every cycle during BUSY -> response is the read of 0x100 and no write occurs.
- Reset mid-BUSY:
  - Accept write 0x400=0xFFFF..FF, assert rst_ni low at cycle 2 -> rvalid, rdata 0 immediately; no pulse after release.
  - A later read of 0x400 returns the old value.
- Wrap/bounds:
  - Without the macro: write 0x4000 data 0xAA..AA, read 0x0000 -> 0xAA..AA.
  - With DMEM_BOUNDS_CHK_EN: err_o=1 on the write response; the read of 0x0000 returns unchanged data.
  - With DMEM_BOUNDS_CHK_EN: a read of 0x4000 returns 0 with err_o=1.
- Minimum latency: LATENCY=1, read accepted at edge k -> rvalid high between edges k+1 and k+2, then IDLE.
